pyc_mem_rd_stream: RTL and testbench

Ready/valid read front-end for the registered-read 1R1W sync memory.
- Accepts read requests (addr + id) on a request channel and drives the memory's `ren`/`raddr`.
- Captures the memory's `rdata` one cycle later, together with the matching id.
- Buffers responses in a small in-order FIFO, so downstream backpressure never loses data, even though the memory itself cannot stall.
- Sits directly upstream of the memory read port, between the requesting pipeline stage and the memory.

---
 rtl/pyc_mem_pkg.sv | 23 ++
 rtl/pyc_mem_rsp_fifo.sv | 63 ++++++
 rtl/pyc_mem_rd_stream.sv | 97 +++++++++
 tb/tb_pyc_mem_rd_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pyc_mem_pkg.sv
// Shared types and sizing helpers for the registered-read memory stream front-end.
package pyc_mem_pkg;

  localparam int PYC_DATA_WIDTH = 64;
  localparam int PYC_ID_WIDTH   = 4;

  // Pointer width for a FIFO of 'depth' entries; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Response entry for the default widths; the top packs {data, id} in this same order.
  typedef struct packed {
    logic [PYC_DATA_WIDTH-1:0] data;
    logic [PYC_ID_WIDTH-1:0]   id;
  } rsp_t;

endpackage

// File: rtl/pyc_mem_rsp_fifo.sv
// In-order response FIFO with push/pop/count/head; any DEPTH >= 2, pointers wrap at DEPTH-1.
module pyc_mem_rsp_fifo
  import pyc_mem_pkg::*;
#(
  parameter int WIDTH = 68,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_width(DEPTH),
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries are only observable once counted in.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pyc_mem_rd_stream.sv
// Ready/valid read front-end for a registered-read 1R1W memory with credit-based response buffering.
// Optional macro PYC_MEM_RD_BYPASS_EN: present read data straight from the memory when the FIFO is empty.
module pyc_mem_rd_stream
  import pyc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic                  busy
);

  localparam int CW = cnt_width(RSP_DEPTH);
  localparam int OW = CW + 1;
  localparam int EW = DATA_WIDTH + ID_WIDTH;

  logic                infl_q, infl_d;
  logic [ID_WIDTH-1:0] infl_id_q, infl_id_d;
  logic                accept;
  logic                rsp_fire;
  logic                fifo_push, fifo_pop, fifo_empty;
  logic [EW-1:0]       fifo_head;
  logic [CW-1:0]       fifo_count;
  logic [OW-1:0]       occ;

  // Credits cover both buffered entries and the read still coming back from memory,
  // so the unconditional capture push can never overflow the FIFO.
  assign occ       = {1'b0, fifo_count} + OW'(infl_q);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign req_ready = rst_n && ((occ < OW'(RSP_DEPTH)) || rsp_fire);

  assign accept    = req_valid && req_ready;
  assign mem_ren   = accept;
  assign mem_raddr = req_addr;

`ifdef PYC_MEM_RD_BYPASS_EN
  logic bypass;

  assign bypass              = fifo_empty && infl_q;
  assign rsp_valid           = !fifo_empty || infl_q;
  assign {rsp_data, rsp_id}  = bypass ? {mem_rdata, infl_id_q} : fifo_head;
  assign fifo_push           = infl_q && !(bypass && rsp_ready);
  assign fifo_pop            = rsp_fire && !fifo_empty;
`else
  assign rsp_valid           = !fifo_empty;
  assign {rsp_data, rsp_id}  = fifo_head;
  assign fifo_push           = infl_q;
  assign fifo_pop            = rsp_fire;
`endif

  assign busy = infl_q || !fifo_empty;

  always_comb begin
    infl_d    = accept;
    infl_id_d = infl_id_q;
    if (accept) infl_id_d = req_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q    <= 1'b0;
      infl_id_q <= '0;
    end else begin
      infl_q    <= infl_d;
      infl_id_q <= infl_id_d;
    end
  end

  pyc_mem_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({mem_rdata, infl_id_q}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_pyc_mem_rd_stream.sv
// Self-checking bench for pyc_mem_rd_stream: vector table, hand sequences and scoreboarded random traffic.
module tb_pyc_mem_rd_stream;
  import pyc_mem_pkg::*;

  localparam int RSP_DEPTH   = 2;
  localparam int RAND_CYCLES = 10000;
`ifdef PYC_MEM_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [63:0] addr;
    logic [3:0]  id;
    logic        rr;
    logic        expReady;
    logic        expValid;
    logic [63:0] expData;
    logic [3:0]  expId;
    logic        expBusy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_ready, rsp_valid, mem_ren, busy;
  logic [63:0] req_addr, mem_raddr, mem_rdata, rsp_data;
  logic [3:0]  req_id, rsp_id;

  logic [63:0] mem [16];
  int          checks = 0;
  int          failures = 0;
  int          mCount = 0;
  bit          mInfl = 1'b0;
  rsp_t        sbq [$];
  vec_t        vecs [$];
  bit          randGo = 1'b0;
  bit          extraDone [2];

  always #5 clk = ~clk;

  // Registered-read memory model: data appears the cycle after ren.
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr[3:0]];

  pyc_mem_rd_stream #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_id(req_id), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle of the reference model: check DUT outputs, then advance model state past the edge.
  task automatic scoreCycle(input string tag, input int depth, inout int cnt, inout bit infl,
                            inout rsp_t q[$], input logic v, input logic [63:0] addr,
                            input logic [3:0] id, input logic rr, input logic dRdy,
                            input logic dRen, input logic dVld, input logic dBsy,
                            input logic [63:0] dRaddr, input logic [63:0] dData,
                            input logic [3:0] dId);
    bit   expValid, expReady, pop, fifoPop, push;
    rsp_t e;
    expValid = (cnt > 0) || (BYP && infl);
    pop      = expValid && rr;
    expReady = ((cnt + int'(infl)) < depth) || pop;
    checkEq({tag, "rsp_valid"}, 64'(dVld), 64'(expValid));
    checkEq({tag, "req_ready"}, 64'(dRdy), 64'(expReady));
    checkEq({tag, "mem_ren"}, 64'(dRen), 64'(v && expReady));
    checkEq({tag, "busy"}, 64'(dBsy), 64'((cnt > 0) || infl));
    if (v && expReady) checkEq({tag, "mem_raddr"}, dRaddr, addr);
    if (dVld && rr) begin
      checkEq({tag, "rsp_has_request"}, 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        checkEq({tag, "rsp_data"}, dData, e.data);
        checkEq({tag, "rsp_id"}, 64'(dId), 64'(e.id));
      end
    end
    if (v && expReady) q.push_back('{data: mem[addr[3:0]], id: id});
    fifoPop = pop && (cnt > 0);
    push    = infl && !(BYP && (cnt == 0) && rr);
    cnt     = cnt + int'(push) - int'(fifoPop);
    infl    = v && expReady;
  endtask

  task automatic checkOutput();
    scoreCycle("", RSP_DEPTH, mCount, mInfl, sbq, req_valid, req_addr, req_id, rsp_ready,
               req_ready, mem_ren, rsp_valid, busy, mem_raddr, rsp_data, rsp_id);
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [3:0] id,
                               input logic rr);
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    req_id    = id;
    rsp_ready = rr;
    #1;
    checkOutput();
  endtask

  task automatic addVec(input logic v, input logic [63:0] a, input logic [3:0] id, input logic rr,
                        input logic er, input logic ev, input logic [63:0] ed,
                        input logic [3:0] eid, input logic eb);
    vecs.push_back('{v: v, addr: a, id: id, rr: rr, expReady: er, expValid: ev,
                     expData: ed, expId: eid, expBusy: eb});
  endtask

  // Extra instances at depths 3 and 5 run independent random traffic alongside the main one.
  for (genvar g = 0; g < 2; g++) begin : gDepth
    localparam int D = (g == 0) ? 3 : 5;
    logic        gV, gRdy, gRr, gVld, gRen, gBsy;
    logic [63:0] gAddr, gRaddr, gRdata, gData;
    logic [3:0]  gId, gRid;

    always @(posedge clk) if (gRen) gRdata <= mem[gRaddr[3:0]];

    pyc_mem_rd_stream #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .RSP_DEPTH(D)) dutX (
      .clk(clk), .rst_n(rst_n), .req_valid(gV), .req_ready(gRdy), .req_addr(gAddr),
      .req_id(gId), .mem_ren(gRen), .mem_raddr(gRaddr), .mem_rdata(gRdata),
      .rsp_valid(gVld), .rsp_ready(gRr), .rsp_data(gData), .rsp_id(gRid), .busy(gBsy)
    );

    initial begin
      int   cnt;
      bit   infl;
      rsp_t q [$];
      string tag;
      cnt = 0;
      infl = 1'b0;
      tag = $sformatf("d%0d_", D);
      gV = 1'b0; gRr = 1'b0; gAddr = '0; gId = '0;
      extraDone[g] = 1'b0;
      wait (randGo);
      for (int i = 0; i < RAND_CYCLES + 30; i++) begin
        @(negedge clk);
        gV    = (i < RAND_CYCLES) ? ($urandom_range(0, 3) != 0) : 1'b0;
        gRr   = (i < RAND_CYCLES) ? ($urandom_range(0, 2) != 0) : 1'b1;
        gAddr = {$urandom(), $urandom()};
        gId   = 4'($urandom());
        #1;
        scoreCycle(tag, D, cnt, infl, q, gV, gAddr, gId, gRr, gRdy, gRen, gVld, gBsy,
                   gRaddr, gData, gRid);
      end
      checkEq({tag, "drained"}, 64'(q.size()), 64'd0);
      extraDone[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? 64'(16 + i) : (64'hA5A5_0000_0000_0000 | 64'(i));
    req_valid = 1'b0; req_addr = '0; req_id = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #2;
    checkEq("reset_req_ready", 64'(req_ready), 64'd0);
    checkEq("reset_mem_ren", 64'(mem_ren), 64'd0);
    checkEq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkEq("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Back-to-back with sink always ready, then a stall-and-release sequence at depth 2.
`ifdef PYC_MEM_RD_BYPASS_EN
    addVec(1, 0, 1, 1, 1, 0, 0, 0, 0);
    addVec(1, 1, 2, 1, 1, 1, 64'h10, 1, 1);
    addVec(1, 2, 3, 1, 1, 1, 64'h11, 2, 1);
    addVec(1, 3, 4, 1, 1, 1, 64'h12, 3, 1);
    addVec(0, 0, 0, 1, 1, 1, 64'h13, 4, 1);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(1, 0, 5, 0, 1, 0, 0, 0, 0);
    addVec(1, 1, 6, 0, 1, 1, 64'h10, 5, 1);
`else
    addVec(1, 0, 1, 1, 1, 0, 0, 0, 0);
    addVec(1, 1, 2, 1, 1, 0, 0, 0, 1);
    addVec(1, 2, 3, 1, 1, 1, 64'h10, 1, 1);
    addVec(1, 3, 4, 1, 1, 1, 64'h11, 2, 1);
    addVec(0, 0, 0, 1, 1, 1, 64'h12, 3, 1);
    addVec(0, 0, 0, 1, 1, 1, 64'h13, 4, 1);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(1, 0, 5, 0, 1, 0, 0, 0, 0);
    addVec(1, 1, 6, 0, 1, 0, 0, 0, 1);
`endif
    addVec(1, 2, 7, 0, 0, 1, 64'h10, 5, 1);
    addVec(1, 2, 7, 0, 0, 1, 64'h10, 5, 1);
    addVec(1, 2, 7, 1, 1, 1, 64'h10, 5, 1);
    addVec(0, 0, 0, 1, 1, 1, 64'h11, 6, 1);
    addVec(0, 0, 0, 1, 1, 1, 64'h12, 7, 1);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tname;
      applyStimulus(vecs[i].v, vecs[i].addr, vecs[i].id, vecs[i].rr);
      tname = $sformatf("vec%0d_", i);
      checkEq({tname, "req_ready"}, 64'(req_ready), 64'(vecs[i].expReady));
      checkEq({tname, "mem_ren"}, 64'(mem_ren), 64'(vecs[i].v && vecs[i].expReady));
      checkEq({tname, "rsp_valid"}, 64'(rsp_valid), 64'(vecs[i].expValid));
      checkEq({tname, "busy"}, 64'(busy), 64'(vecs[i].expBusy));
      if (vecs[i].expValid) begin
        checkEq({tname, "rsp_data"}, rsp_data, vecs[i].expData);
        checkEq({tname, "rsp_id"}, 64'(rsp_id), 64'(vecs[i].expId));
      end
    end

    // Reset mid-flight: one entry buffered and one read in flight, then rst_n drops between edges.
    applyStimulus(1, 3, 9, 0);
    applyStimulus(1, 2, 10, 0);
    @(posedge clk);
    #3;
    checkEq("pre_reset_busy", 64'(busy), 64'd1);
    checkEq("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkEq("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkEq("midreset_busy", 64'(busy), 64'd0);
    checkEq("midreset_req_ready", 64'(req_ready), 64'd0);
    mCount = 0;
    mInfl = 1'b0;
    sbq.delete();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);

    // Random traffic on all three depths concurrently.
    randGo = 1'b1;
    for (int i = 0; i < RAND_CYCLES; i++)
      applyStimulus($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 4'($urandom()),
                    $urandom_range(0, 2) != 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 1);
    checkEq("main_drained", 64'(sbq.size()), 64'd0);

    for (int i = 0; i < 200; i++) begin
      if (extraDone[0] && extraDone[1]) break;
      @(negedge clk);
    end
    checkEq("extra_done", {62'd0, extraDone[1], extraDone[0]}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
